rv_mem_arbiter: RTL and testbench

Shares one single-port unified memory between the instruction-fetch port (IF stage) and the data-access port (MEM stage) of the 5-stage core. Only one transaction is in flight at a time. The data port normally wins; an instruction-starvation counter guarantees forward progress. The block generates per-port stall signals that the core uses in place of the fixed one-cycle memories, and it discards fetch responses that are invalidated by IF_flush.

---
 rtl/rv_pkg.sv | 6 +
 rtl/rv_mem_arbiter_if.sv | 41 ++++
 rtl/rv_arb_pick.sv | 27 ++
 rtl/rv_mem_arbiter.sv | 97 +++++++++
 tb/tb_rv_mem_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared FSM/owner encodings and defaults for the unified-memory arbiter
package rv_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;
    localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/rv_mem_arbiter_if.sv
// rv_mem_arbiter_if: fetch port, data port and memory-side signals of the arbiter
interface rv_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_done_o;
    logic [31:0]       if_rdata_o;
    logic              if_stall_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W/8-1:0] dm_wstrb_i;
    logic              dm_done_o;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W/8-1:0] mem_wstrb_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_wstrb_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_done_o, if_rdata_o, if_stall_o, dm_done_o, dm_rdata_o, dm_stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );
    modport master (
        output if_req_i, if_addr_i, if_flush_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_wstrb_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_done_o, if_rdata_o, if_stall_o, dm_done_o, dm_rdata_o, dm_stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );
endinterface

// File: rtl/rv_arb_pick.sv
// rv_arb_pick: data-priority winner select with an instruction-starvation counter
module rv_arb_pick import rv_pkg::*; #(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   en,
    input  logic   if_req,
    input  logic   dm_req,
    output logic   valid,
    output owner_e owner
);
    logic [3:0] starve_cnt;
    logic       pick_if;

    assign pick_if = if_req && (!dm_req || starve_cnt == 4'(STARVE_MAX));
    assign valid   = if_req || dm_req;
    assign owner   = pick_if ? OWN_IF : OWN_DM;

    // Only data wins taken while a fetch waits count toward starvation
    always_ff @(posedge clk) begin
        if (!rstn)
            starve_cnt <= '0;
        else if (en && valid)
            starve_cnt <= pick_if ? 4'd0 : if_req ? starve_cnt + 4'd1 : starve_cnt;
    end
endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one single-port memory between the fetch and data ports,
// one transaction in flight, with flush-driven discard of stale fetch responses
module rv_mem_arbiter import rv_pkg::*; #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic             clk,
    input logic             rstn,
    rv_mem_arbiter_if.slave bus
);
    state_e              state_q, state_d;
    owner_e              owner_q, gnt_owner;
    logic                gnt_valid, arb_en, latch, resp, flush_hit;
    logic                discard_q, if_done_q, dm_done_q, we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, dm_rdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [31:0]         if_rdata_q;

    rv_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk    (clk),
        .rstn   (rstn),
        .en     (arb_en),
        .if_req (bus.if_req_i),
        .dm_req (bus.dm_req_i),
        .valid  (gnt_valid),
        .owner  (gnt_owner)
    );

    always_ff @(posedge clk) begin
        if (!rstn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = gnt_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = bus.mem_gnt_i ? ST_WAIT : ST_ISSUE;
            ST_WAIT:  state_d = bus.mem_rvalid_i ? ST_RESP : ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        arb_en    = state_q == ST_IDLE;
        latch     = arb_en && gnt_valid;
        resp      = state_q == ST_WAIT && bus.mem_rvalid_i;
        flush_hit = bus.if_flush_i && owner_q == OWN_IF && state_q != ST_IDLE;
    end

    // Done is registered on the WAIT->RESP edge so it is high exactly while in RESP
    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            discard_q  <= 1'b0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (latch) begin
                owner_q <= gnt_owner;
                addr_q  <= gnt_owner == OWN_DM ? bus.dm_addr_i : bus.if_addr_i;
                we_q    <= gnt_owner == OWN_DM && bus.dm_we_i;
                wdata_q <= bus.dm_wdata_i;
                wstrb_q <= gnt_owner == OWN_DM ? bus.dm_wstrb_i : '0;
            end
            discard_q <= state_q == ST_RESP ? 1'b0 : discard_q || flush_hit;
            if_done_q <= resp && owner_q == OWN_IF && !(discard_q || flush_hit);
            dm_done_q <= resp && owner_q == OWN_DM;
            if (resp && owner_q == OWN_IF)
                if_rdata_q <= addr_q[2] ? bus.mem_rdata_i[63:32] : bus.mem_rdata_i[31:0];
            if (resp && owner_q == OWN_DM)
                dm_rdata_q <= bus.mem_rdata_i;
        end
    end

    assign bus.mem_req_o   = state_q == ST_ISSUE;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_wstrb_o = wstrb_q;
    assign bus.if_done_o   = if_done_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_done_o   = dm_done_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.if_stall_o  = bus.if_req_i && !if_done_q;
    assign bus.dm_stall_o  = bus.dm_req_i && !dm_done_q;
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: directed scenarios plus randomized traffic against a memory model
// and an arbitration/data reference model kept in the bench
module tb_rv_mem_arbiter;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    rv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    int          gnt_block = 0;
    int          rv_wait   = 0;
    bit          rand_mode = 0;
    bit          spur      = 0;
    bit          force_en  = 0;
    logic [63:0] force_data = '0;
    bit          grant_q[$];
    int          streak = 0;

    logic        neg_if_req, neg_dm_req, neg_rstn;
    logic [63:0] neg_if_addr, neg_dm_addr;

    function automatic logic [63:0] data_of(input logic [63:0] a);
        return {a[31:0] ^ 32'h1357_9BDF, a[31:0] * 32'h9E37_79B9 + 32'h0BAD_F00D};
    endfunction

    function automatic logic [31:0] word_of(input logic [63:0] a);
        logic [63:0] d;
        d = data_of(a);
        return a[2] ? d[63:32] : d[31:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        neg_if_req  <= bus.if_req_i;
        neg_dm_req  <= bus.dm_req_i;
        neg_if_addr <= bus.if_addr_i;
        neg_dm_addr <= bus.dm_addr_i;
        neg_rstn    <= rstn;
    end

    // Memory model plus arbitration reference: dm wins unless a fetch has waited SMAX data grants
    initial begin : mem_model
        bit          req_seen, acc, pend, dm_win, exp_dm;
        int          cnt;
        logic [63:0] addr_seen, pdata;
        req_seen = 0; pend = 0; cnt = 0; addr_seen = '0; pdata = '0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
        forever begin
            tick;
            acc = bus.mem_gnt_i && req_seen;
            bus.mem_rvalid_i = 0;
            if (acc) begin
                pend  = 1;
                cnt   = rand_mode ? $urandom_range(0, 3) : rv_wait;
                pdata = force_en ? force_data : data_of(addr_seen);
            end
            if (pend) begin
                if (cnt == 0) begin
                    bus.mem_rvalid_i = 1; bus.mem_rdata_i = pdata; pend = 0;
                end else cnt--;
            end
            if (spur) begin
                bus.mem_rvalid_i = 1; bus.mem_rdata_i = '1; spur = 0;
            end
            if (!neg_rstn) streak = 0;
            if (bus.mem_req_o && !req_seen) begin
                dm_win = neg_dm_req && bus.mem_addr_o == neg_dm_addr;
                exp_dm = neg_dm_req && !(neg_if_req && streak == SMAX);
                n_cmp++;
                if (dm_win !== exp_dm) begin
                    n_err++;
                    $display("FAIL grant_owner t=%0t: got dm=%0b expected dm=%0b (if_req=%0b dm_req=%0b streak=%0d)",
                             $time, dm_win, exp_dm, neg_if_req, neg_dm_req, streak);
                end
                streak = !exp_dm ? 0 : neg_if_req ? streak + 1 : streak;
                grant_q.push_back(dm_win);
            end else if (req_seen && !acc && neg_rstn) begin
                n_cmp++;
                if (!bus.mem_req_o || bus.mem_addr_o !== addr_seen) begin
                    n_err++;
                    $display("FAIL issue_hold t=%0t: req=%0b addr=%h expected req=1 addr=%h",
                             $time, bus.mem_req_o, bus.mem_addr_o, addr_seen);
                end
            end
            req_seen  = bus.mem_req_o;
            addr_seen = bus.mem_addr_o;
            if (req_seen && gnt_block > 0) begin
                bus.mem_gnt_i = 0; gnt_block--;
            end else
                bus.mem_gnt_i = req_seen && (!rand_mode || $urandom_range(0, 1) == 1);
        end
    end

    task automatic do_reset;
        bus.if_req_i = 0; bus.if_addr_i = '0; bus.if_flush_i = 0;
        bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0; bus.dm_wstrb_i = '0;
        gnt_block = 0; rv_wait = 0; rand_mode = 0; force_en = 0;
        rstn = 0;
        tick; tick;
        rstn = 1;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++;
        if ({bus.if_done_o, bus.dm_done_o, bus.mem_req_o, bus.mem_we_o} !== 4'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 0000",
                              {bus.if_done_o, bus.dm_done_o, bus.mem_req_o, bus.mem_we_o});
        end
        n_cmp++;
        if ({bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o} !== '0) begin
            n_err++; $display("FAIL reset_mem: addr=%h wdata=%h wstrb=%h expected 0",
                              bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o);
        end
        n_cmp++;
        if (bus.if_rdata_o !== 32'h0 || bus.dm_rdata_o !== 64'h0) begin
            n_err++; $display("FAIL reset_rdata: if=%h dm=%h expected 0", bus.if_rdata_o, bus.dm_rdata_o);
        end
    endtask

    task automatic test_single_load;
        do_reset;
        force_en = 1; force_data = 64'hDEADBEEF_00000001;
        bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 64'h100;
        #1;
        n_cmp++;
        if (bus.dm_stall_o !== 1'b1) begin n_err++; $display("FAIL load_stall c0: got %b expected 1", bus.dm_stall_o); end
        for (int c = 1; c <= 3; c++) begin
            tick;
            n_cmp++;
            if (c < 3 && (bus.dm_done_o !== 1'b0 || bus.dm_stall_o !== 1'b1)) begin
                n_err++; $display("FAIL load_wait c%0d: done=%b stall=%b expected done=0 stall=1", c, bus.dm_done_o, bus.dm_stall_o);
            end
            if (c == 3 && (bus.dm_done_o !== 1'b1 || bus.dm_stall_o !== 1'b0 || bus.dm_rdata_o !== 64'hDEADBEEF_00000001)) begin
                n_err++; $display("FAIL load_done c3: done=%b stall=%b rdata=%h expected 1/0/deadbeef00000001",
                                  bus.dm_done_o, bus.dm_stall_o, bus.dm_rdata_o);
            end
        end
        bus.dm_req_i = 0;
        tick;
        force_en = 0;
        n_cmp++;
        if (bus.dm_done_o !== 1'b0) begin n_err++; $display("FAIL load_pulse: done=%b expected 0", bus.dm_done_o); end
    endtask

    task automatic test_contention;
        int w;
        do_reset;
        grant_q.delete();
        bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 64'h1000;
        bus.if_req_i = 1; bus.if_addr_i = 64'h200;
        for (w = 0; w < 300 && grant_q.size() < 11; w++) tick;
        bus.dm_req_i = 0; bus.if_req_i = 0;
        repeat (10) tick;
        n_cmp++;
        if (grant_q.size() < 11) begin
            n_err++; $display("FAIL contention_timeout: got %0d grants expected 11", grant_q.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_cmp++;
                if (grant_q[i] !== ((i % 5) != 4)) begin
                    n_err++; $display("FAIL contention_order[%0d]: got dm=%0b expected dm=%0b", i, grant_q[i], (i % 5) != 4);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        gnt_block = 5;
        bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 64'h2000;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c == 2) spur = 1;
            if (c <= 5) begin
                n_cmp++;
                if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 64'h2000) begin
                    n_err++; $display("FAIL bp_hold c%0d: req=%b addr=%h expected 1/2000", c, bus.mem_req_o, bus.mem_addr_o);
                end
            end
            n_cmp++;
            if (c < 8 && bus.dm_done_o !== 1'b0) begin
                n_err++; $display("FAIL bp_early c%0d: done=%b expected 0", c, bus.dm_done_o);
            end
            if (c == 8 && (bus.dm_done_o !== 1'b1 || bus.dm_rdata_o !== data_of(64'h2000))) begin
                n_err++; $display("FAIL bp_done c8: done=%b rdata=%h expected 1/%h", bus.dm_done_o, bus.dm_rdata_o, data_of(64'h2000));
            end
        end
        bus.dm_req_i = 0;
        tick;
    endtask

    task automatic test_flush;
        bit seen, got;
        int c;
        do_reset;
        rv_wait = 2;
        bus.if_req_i = 1; bus.if_addr_i = 64'h8;
        tick; tick;
        bus.if_flush_i = 1; bus.if_req_i = 0;
        tick;
        bus.if_flush_i = 0;
        seen = 0;
        repeat (10) begin
            if (bus.if_done_o) seen = 1;
            tick;
        end
        n_cmp++;
        if (seen) begin n_err++; $display("FAIL flush_discard: if_done seen=1 expected 0"); end
        rv_wait = 0;
        bus.if_req_i = 1; bus.if_addr_i = 64'h44;
        got = 0;
        for (c = 1; c <= 20 && !got; c++) begin
            tick;
            got = bus.if_done_o;
        end
        bus.if_req_i = 0;
        n_cmp++;
        if (!got || bus.if_rdata_o !== data_of(64'h44) >> 32 || c - 1 != 3) begin
            n_err++; $display("FAIL flush_refetch: done=%b cyc=%0d rdata=%h expected 1/3/%h",
                              got, c - 1, bus.if_rdata_o, data_of(64'h44) >> 32);
        end
        tick;
    endtask

    task automatic test_store;
        logic [63:0] wd;
        int cnt, first;
        do_reset;
        wd = {$urandom, $urandom};
        bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_addr_i = 64'h3000; bus.dm_wdata_i = wd; bus.dm_wstrb_i = 8'h0F;
        cnt = 0; first = 0;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c == 1) begin
                n_cmp++;
                if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_wstrb_o !== 8'h0F ||
                    bus.mem_wdata_o !== wd || bus.mem_addr_o !== 64'h3000) begin
                    n_err++; $display("FAIL store_issue: req=%b we=%b wstrb=%h wdata=%h addr=%h expected 1/1/0f/%h/3000",
                                      bus.mem_req_o, bus.mem_we_o, bus.mem_wstrb_o, bus.mem_wdata_o, bus.mem_addr_o, wd);
                end
            end
            if (bus.dm_done_o) begin
                cnt++;
                if (first == 0) first = c;
                bus.dm_req_i = 0;
            end
        end
        n_cmp++;
        if (cnt != 1 || first != 3) begin
            n_err++; $display("FAIL store_done: pulses=%0d first=c%0d expected 1 at c3", cnt, first);
        end
        bus.dm_we_i = 0;
    endtask

    task automatic test_reset_wait;
        bit seen, got;
        int c;
        do_reset;
        rv_wait = 3;
        bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 64'h4000;
        tick; tick;
        rstn = 0; bus.dm_req_i = 0;
        tick;
        rstn = 1;
        n_cmp++;
        if ({bus.if_done_o, bus.dm_done_o, bus.mem_req_o, bus.mem_we_o} !== 4'b0 ||
            bus.mem_addr_o !== '0 || bus.dm_rdata_o !== '0 || bus.if_rdata_o !== '0) begin
            n_err++; $display("FAIL rstwait_zero: done=%b/%b req=%b addr=%h dm_rdata=%h expected all 0",
                              bus.if_done_o, bus.dm_done_o, bus.mem_req_o, bus.mem_addr_o, bus.dm_rdata_o);
        end
        seen = 0;
        repeat (8) begin
            tick;
            if (bus.dm_done_o || bus.if_done_o) seen = 1;
        end
        n_cmp++;
        if (seen) begin n_err++; $display("FAIL rstwait_stale: done seen=1 expected 0"); end
        rv_wait = 0;
        bus.dm_req_i = 1; bus.dm_addr_i = 64'h4100;
        got = 0;
        for (c = 1; c <= 20 && !got; c++) begin
            tick;
            got = bus.dm_done_o;
        end
        bus.dm_req_i = 0;
        n_cmp++;
        if (!got || c - 1 != 3 || bus.dm_rdata_o !== data_of(64'h4100)) begin
            n_err++; $display("FAIL rstwait_new: done=%b cyc=%0d rdata=%h expected 1/3/%h",
                              got, c - 1, bus.dm_rdata_o, data_of(64'h4100));
        end
        tick;
    endtask

    task automatic drive_if(input int n);
        logic [63:0] a;
        bit fl, got, seen;
        int w;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) tick;
            a = 64'($urandom_range(0, 255)) << 2;
            fl = $urandom_range(0, 3) == 0;
            bus.if_addr_i = a; bus.if_req_i = 1; got = 0;
            for (w = 0; w < 300 && !got; w++) begin
                tick;
                n_cmp++;
                if (bus.if_stall_o !== !bus.if_done_o) begin
                    n_err++; $display("FAIL rnd_if_stall: got %b expected %b", bus.if_stall_o, !bus.if_done_o);
                end
                if (fl && bus.mem_req_o && bus.mem_addr_o == a) begin
                    got = 1;
                    bus.if_flush_i = 1; bus.if_req_i = 0;
                    tick;
                    bus.if_flush_i = 0;
                    seen = 0;
                    repeat (30) begin
                        if (bus.if_done_o) seen = 1;
                        tick;
                    end
                    n_cmp++;
                    if (seen) begin n_err++; $display("FAIL rnd_if_flush addr=%h: if_done seen=1 expected 0", a); end
                end else if (bus.if_done_o) begin
                    got = 1;
                    n_cmp++;
                    if (bus.if_rdata_o !== word_of(a)) begin
                        n_err++; $display("FAIL rnd_if_data addr=%h: got %h expected %h", a, bus.if_rdata_o, word_of(a));
                    end
                end
            end
            bus.if_req_i = 0;
            if (!got) begin n_cmp++; n_err++; $display("FAIL rnd_if_timeout addr=%h: no done expected done", a); end
        end
    endtask

    task automatic drive_dm(input int n);
        logic [63:0] a;
        bit got, we;
        int w;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) tick;
            a = 64'h1000 + (64'($urandom_range(0, 255)) << 3);
            we = $urandom_range(0, 1) == 1;
            bus.dm_addr_i = a; bus.dm_we_i = we; bus.dm_wdata_i = {$urandom, $urandom};
            bus.dm_wstrb_i = 8'($urandom); bus.dm_req_i = 1; got = 0;
            for (w = 0; w < 300 && !got; w++) begin
                tick;
                n_cmp++;
                if (bus.dm_stall_o !== !bus.dm_done_o) begin
                    n_err++; $display("FAIL rnd_dm_stall: got %b expected %b", bus.dm_stall_o, !bus.dm_done_o);
                end
                if (bus.dm_done_o) begin
                    got = 1;
                    if (!we) begin
                        n_cmp++;
                        if (bus.dm_rdata_o !== data_of(a)) begin
                            n_err++; $display("FAIL rnd_dm_data addr=%h: got %h expected %h", a, bus.dm_rdata_o, data_of(a));
                        end
                    end
                end
            end
            bus.dm_req_i = 0;
            if (!got) begin n_cmp++; n_err++; $display("FAIL rnd_dm_timeout addr=%h: no done expected done", a); end
        end
    endtask

    task automatic test_random;
        do_reset;
        rand_mode = 1;
        fork
            drive_if(30);
            drive_dm(40);
        join
        repeat (20) tick;
        rand_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish expected finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single_load;
        test_contention;
        test_backpressure;
        test_flush;
        test_store;
        test_reset_wait;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
